// File: rtl/bitonic_pkg.sv
// Shared helpers for the pipelined bitonic sorter: stage count and the
// mapping from a flat stage number to its merge size and compare distance.
package bitonic_pkg;

    localparam int MAX_LOG_N = 6;

    // Number of compare stages in a full bitonic sort of 2**log_n elements.
    function automatic int num_stages(input int log_n);
        return log_n * (log_n + 1) / 2;
    endfunction

    // log2 of the merge (bitonic block) size handled by flat stage s.
    function automatic int stage_merge_log(input int s);
        int p;
        p = MAX_LOG_N;
        for (int k = MAX_LOG_N; k >= 1; k--) begin
            if (s < num_stages(k)) p = k;
        end
        return p;
    endfunction

    // log2 of the partner distance used by flat stage s.
    function automatic int stage_dist_log(input int s);
        int p;
        p = stage_merge_log(s);
        return p - 1 - (s - num_stages(p - 1));
    endfunction

endpackage

// File: rtl/cmp_swap.sv
// Combinational compare-exchange element. Orders two (key, idx) pairs by
// the concatenation {key, idx}; dir=0 puts the smaller pair first.
module cmp_swap #(
    parameter int WIDTH = 8,
    parameter int IDXW  = 3
) (
    input  logic [WIDTH-1:0] a_key,
    input  logic [IDXW-1:0]  a_idx,
    input  logic [WIDTH-1:0] b_key,
    input  logic [IDXW-1:0]  b_idx,
    input  logic             dir,
    output logic [WIDTH-1:0] lo_key,
    output logic [IDXW-1:0]  lo_idx,
    output logic [WIDTH-1:0] hi_key,
    output logic [IDXW-1:0]  hi_idx
);

    logic a_gt_b;
    logic swap;

    // Index tags are unique within a vector, so the two pairs never compare
    // equal and flipping the greater-than result fully reverses the order.
    always_comb begin
        a_gt_b = {a_key, a_idx} > {b_key, b_idx};
        swap   = a_gt_b ^ dir;
        lo_key = swap ? b_key : a_key;
        lo_idx = swap ? b_idx : a_idx;
        hi_key = swap ? a_key : b_key;
        hi_idx = swap ? a_idx : b_idx;
    end

endmodule

// File: rtl/bitonic_sort_pipe.sv
// Fully pipelined bitonic sorter. Register 0 captures the input vector and
// tags each element with its position; each of the S compare stages is then
// followed by its own register, so register S is the output stage.
// The whole pipe freezes while the output is held by the consumer.
module bitonic_sort_pipe
    import bitonic_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int LOG_N = 3,
    localparam int N     = 2 ** LOG_N,
    localparam int IDXW  = LOG_N
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_desc,
    input  logic [WIDTH-1:0] in_data [0:N-1],
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_desc,
    output logic [WIDTH-1:0] out_data [0:N-1],
    output logic [IDXW-1:0]  out_idx [0:N-1],
    output logic             busy
);

    localparam int S = num_stages(LOG_N);

    // Register r holds the vector after r compare stages.
    logic [WIDTH-1:0] key_r  [0:S][0:N-1];
    logic [IDXW-1:0]  idx_r  [0:S][0:N-1];
    logic             desc_r [0:S];
    logic             vld_r  [0:S];

    // Comparator outputs of stage s, feeding register s+1.
    logic [WIDTH-1:0] key_c  [0:S-1][0:N-1];
    logic [IDXW-1:0]  idx_c  [0:S-1][0:N-1];

    logic stall;
    logic en;
    logic take;

    // Global pipe enable and input acceptance.
    always_comb begin
        stall    = vld_r[S] & ~out_ready;
        en       = ~stall;
        in_ready = ~stall & ~rst;
        take     = in_valid & in_ready;
    end

    // Input register: capture keys, assign position tags, latch mode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                key_r[0][i] <= '0;
                idx_r[0][i] <= '0;
            end
            desc_r[0] <= 1'b0;
            vld_r[0]  <= 1'b0;
        end else if (en) begin
            for (int i = 0; i < N; i++) begin
                key_r[0][i] <= in_data[i];
                idx_r[0][i] <= IDXW'(i);
            end
            desc_r[0] <= in_desc;
            vld_r[0]  <= take;
        end
    end

    for (genvar s = 0; s < S; s++) begin : g_stage
        localparam int P = stage_merge_log(s);
        localparam int Q = stage_dist_log(s);

        for (genvar i = 0; i < N; i++) begin : g_elem
            localparam int L = i ^ (1 << Q);
            if (L > i) begin : g_cmp
                // Network direction alternates per merge block; in the final
                // merge (P == LOG_N) every block is ascending.
                localparam logic NET_DIR = ((i >> P) % 2) == 1;
                cmp_swap #(
                    .WIDTH (WIDTH),
                    .IDXW  (IDXW)
                ) u_cmp (
                    .a_key  (key_r[s][i]),
                    .a_idx  (idx_r[s][i]),
                    .b_key  (key_r[s][L]),
                    .b_idx  (idx_r[s][L]),
                    .dir    (NET_DIR ^ desc_r[s]),
                    .lo_key (key_c[s][i]),
                    .lo_idx (idx_c[s][i]),
                    .hi_key (key_c[s][L]),
                    .hi_idx (idx_c[s][L])
                );
            end
        end

        // Stage register: advance comparator results, mode and valid bit.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int i = 0; i < N; i++) begin
                    key_r[s+1][i] <= '0;
                    idx_r[s+1][i] <= '0;
                end
                desc_r[s+1] <= 1'b0;
                vld_r[s+1]  <= 1'b0;
            end else if (en) begin
                for (int i = 0; i < N; i++) begin
                    key_r[s+1][i] <= key_c[s][i];
                    idx_r[s+1][i] <= idx_c[s][i];
                end
                desc_r[s+1] <= desc_r[s];
                vld_r[s+1]  <= vld_r[s];
            end
        end
    end

    // Output stage drives the ports directly; busy covers every register.
    always_comb begin
        out_valid = vld_r[S];
        out_desc  = desc_r[S];
        for (int i = 0; i < N; i++) begin
            out_data[i] = key_r[S][i];
            out_idx[i]  = idx_r[S][i];
        end
        busy = 1'b0;
        for (int s = 0; s <= S; s++) begin
            busy = busy | vld_r[s];
        end
    end

endmodule

// File: tb/tb_bitonic_sort_pipe.sv
// Directed bench for bitonic_sort_pipe at the default size (N=8, WIDTH=8).
// Vectors and their sorted results are written out by hand in the tables.
module tb_bitonic_sort_pipe;

    localparam int WIDTH = 8;
    localparam int LOG_N = 3;
    localparam int N     = 8;
    localparam int IDXW  = 3;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic             in_desc;
    logic [WIDTH-1:0] in_data [0:N-1];
    logic             out_valid;
    logic             out_ready;
    logic             out_desc;
    logic [WIDTH-1:0] out_data [0:N-1];
    logic [IDXW-1:0]  out_idx [0:N-1];
    logic             busy;

    int n_cmp;
    int n_bad;

    // Input vectors (element 0 in the top byte) and their expected results.
    logic [63:0] vec_key [0:5];
    logic        vec_desc [0:5];
    logic [63:0] exp_key [0:5];
    logic [63:0] exp_idx [0:5];

    bitonic_sort_pipe #(
        .WIDTH (WIDTH),
        .LOG_N (LOG_N)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_desc   (in_desc),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_desc  (out_desc),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] pack_keys();
        logic [63:0] r;
        for (int i = 0; i < N; i++) r[63-8*i -: 8] = out_data[i];
        return r;
    endfunction

    function automatic logic [63:0] pack_idx();
        logic [63:0] r;
        for (int i = 0; i < N; i++) r[63-8*i -: 8] = 8'(out_idx[i]);
        return r;
    endfunction

    // Present vector n for one edge (caller ensures in_ready) and drop valid.
    task automatic send(input int n);
        in_valid = 1'b1;
        in_desc  = vec_desc[n];
        for (int i = 0; i < N; i++) in_data[i] = vec_key[n][63-8*i -: 8];
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Wait (bounded) for out_valid, returning the number of edges waited.
    task automatic wait_out(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic check_vec(input string tag, input int n);
        chk({tag, "_data"}, pack_keys(), exp_key[n]);
        chk({tag, "_idx"},  pack_idx(),  exp_idx[n]);
        chk({tag, "_desc"}, 64'(out_desc), 64'(vec_desc[n]));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int first;
        int last;
        int got;
        int seen;

        n_cmp = 0;
        n_bad = 0;

        vec_key[0] = 64'h05030701_00FF0302; vec_desc[0] = 1'b0;
        exp_key[0] = 64'h00010203_030507FF; exp_idx[0] = 64'h04030701_06000205;
        vec_key[1] = 64'h05030701_00FF0302; vec_desc[1] = 1'b1;
        exp_key[1] = 64'hFF070503_03020100; exp_idx[1] = 64'h05020006_01070304;
        vec_key[2] = 64'h08070605_04030201; vec_desc[2] = 1'b0;
        exp_key[2] = 64'h01020304_05060708; exp_idx[2] = 64'h07060504_03020100;
        vec_key[3] = 64'h01020304_05060708; vec_desc[3] = 1'b1;
        exp_key[3] = 64'h08070605_04030201; exp_idx[3] = 64'h07060504_03020100;
        vec_key[4] = 64'hFF00FF00_FF00FF00; vec_desc[4] = 1'b0;
        exp_key[4] = 64'h00000000_FFFFFFFF; exp_idx[4] = 64'h01030507_00020406;
        vec_key[5] = 64'h09090909_09090909; vec_desc[5] = 1'b1;
        exp_key[5] = 64'h09090909_09090909; exp_idx[5] = 64'h07060504_03020100;

        rst       = 1'b0;
        in_valid  = 1'b0;
        in_desc   = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < N; i++) in_data[i] = '0;

        // Reset asserted between edges takes effect immediately.
        #2 rst = 1'b1;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy",      64'(busy),      64'd0);
        chk("rst_data",      pack_keys(),    64'd0);
        chk("rst_idx",       pack_idx(),     64'd0);
        chk("rst_desc",      64'(out_desc),  64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd0);
        @(posedge clk); @(posedge clk); #2;
        rst = 1'b0;
        #1;
        chk("idle_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;

        // Single ascending vector.
        send(0);
        chk("asc_busy", 64'(busy), 64'd1);
        wait_out(cyc);
        chk("asc_lat", 64'(cyc), 64'd6);
        check_vec("asc", 0);
        @(posedge clk); #1;
        chk("asc_drain", 64'(out_valid), 64'd0);

        // Single descending vector.
        send(1);
        wait_out(cyc);
        chk("desc_lat", 64'(cyc), 64'd6);
        check_vec("desc", 1);
        @(posedge clk); #1;
        chk("idle_busy", 64'(busy), 64'd0);

        // Six vectors back to back, alternating mode.
        first = -1;
        last  = -1;
        got   = 0;
        fork
            begin
                for (int v = 0; v < 6; v++) send(v);
            end
            begin
                for (int c = 1; c <= 30; c++) begin
                    @(posedge clk); #1;
                    if (out_valid) begin
                        if (first < 0) first = c;
                        last = c;
                        if (got < 6) check_vec("b2b", got);
                        got++;
                    end
                end
            end
        join
        chk("b2b_count", 64'(got),          64'd6);
        chk("b2b_first", 64'(first),        64'd7);
        chk("b2b_span",  64'(last - first), 64'd5);

        // Backpressure: three vectors pile up behind a held output.
        out_ready = 1'b0;
        send(2);
        send(3);
        send(4);
        wait_out(cyc);
        chk("bp_lat", 64'(cyc), 64'd4);
        in_valid = 1'b1;
        in_desc  = vec_desc[5];
        for (int i = 0; i < N; i++) in_data[i] = vec_key[5][63-8*i -: 8];
        for (int k = 0; k < 3; k++) begin
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_valid",    64'(out_valid), 64'd1);
            check_vec("bp_hold", 2);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 15; c++) begin
            if (out_valid && out_ready) begin
                if (got < 3) check_vec("bp_out", got + 2);
                got++;
            end
            @(posedge clk); #1;
        end
        chk("bp_count", 64'(got), 64'd3);

        // Reset while three vectors are in flight.
        send(0);
        send(1);
        send(2);
        #3 rst = 1'b1;
        #1;
        chk("rmf_out_valid", 64'(out_valid), 64'd0);
        chk("rmf_busy",      64'(busy),      64'd0);
        chk("rmf_data",      pack_keys(),    64'd0);
        chk("rmf_in_ready",  64'(in_ready),  64'd0);
        @(posedge clk); #2;
        rst = 1'b0;
        @(posedge clk); #1;
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            if (out_valid) seen++;
            @(posedge clk); #1;
        end
        chk("rmf_flushed", 64'(seen), 64'd0);
        send(3);
        wait_out(cyc);
        chk("rmf_lat", 64'(cyc), 64'd6);
        check_vec("rmf", 3);
        @(posedge clk); #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
